// File: rtl/booth_mul.sv
// Sequential signed WIDTH x WIDTH -> 2*WIDTH radix-2 Booth multiplier, one recode step per clock.
// Define BOOTH_OVF_EN to register the signed-WIDTH overflow flag; otherwise ovf is tied low.
module booth_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic               ovf
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     nm_q, nm_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     step_acc;
  logic [WIDTH-1:0]   step_q;
  logic               step_q1;
  logic               accept;

  // One Booth step on the current registers: add/sub, then arithmetic shift of {ACC, Q, Q_1}.
  always_comb begin
    a_ext = {a[WIDTH-1], a};
    case ({q_q[0], q1_q})
      2'b01:   addend = m_q;
      2'b10:   addend = nm_q;
      default: addend = '0;
    endcase
    sum      = acc_q + addend;
    step_acc = {sum[WIDTH], sum[WIDTH:1]};
    step_q   = {sum[0], q_q[WIDTH-1:1]};
    step_q1  = q_q[0];
  end

  // DONE also accepts a new request so back-to-back operations run every 33 cycles.
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    nm_d    = nm_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    p_d     = p_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d = StRun;
          m_d     = a_ext;
          nm_d    = ~a_ext + (WIDTH+1)'(1);
          acc_d   = '0;
          q_d     = b;
          q1_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        acc_d = step_acc;
        q_d   = step_q;
        q1_d  = step_q1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          p_d     = {step_acc[WIDTH-1:0], step_q};
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      m_q     <= '0;
      nm_q    <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      nm_q    <= nm_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

`ifdef BOOTH_OVF_EN
  logic ovf_q, ovf_d;
  logic [WIDTH:0] p_hi;

  // The product fits in signed WIDTH bits only if its upper WIDTH+1 bits are all equal.
  always_comb begin
    p_hi  = p_d[2*WIDTH-1:WIDTH-1];
    ovf_d = ovf_q;
    if ((state_q == StRun) && (state_d == StDone)) begin
      ovf_d = ~(&p_hi | ~(|p_hi));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mul.sv
// Self-checking bench for booth_mul: vector table, random ops against a product model,
// and hand-written sequences for ignored starts, back-to-back accept and mid-run reset.
module tb_booth_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] p;
  logic        ovf;

  always #5 clk = ~clk;

  booth_mul #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .ovf   (ovf)
  );

`ifdef BOOTH_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] p;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic        ovf_raw;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  vec_t vecs[10];

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint pr;
    pr    = longint'($signed(x)) * longint'($signed(y));
    e.p   = pr;
    e.ovf = OvfEn && ((pr > 64'sd2147483647) || (pr < -64'sd2147483648));
    return e;
  endfunction

  // Drive a one-cycle start; optionally record the expected result.
  task automatic launch(input logic [31:0] x, input logic [31:0] y, input bit push,
                        input logic [63:0] ep, input logic eo);
    exp_t e;
    e.p   = ep;
    e.ovf = eo;
    if (push) sb.push_back(e);
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy after accept", {63'd0, busy}, 64'd1);
  endtask

  // Wait (bounded) for done, compare latency and result, then one more edge for busy.
  task automatic finish_op(input string tag, input int exp_lat, input logic exp_busy_after);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, " done seen"}, {63'd0, done}, 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " scoreboard depth"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " p"}, p, e.p);
      check({tag, " ovf"}, {63'd0, ovf}, {63'd0, e.ovf});
    end
    tick();
    check({tag, " done width"}, {63'd0, done}, 64'd0);
    check({tag, " busy after done"}, {63'd0, busy}, {63'd0, exp_busy_after});
  endtask

  initial begin
    int   d0;
    exp_t e;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0};
    vecs[1] = '{32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0};
    vecs[2] = '{32'd6, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1};
    vecs[4] = '{32'd0, 32'd123, 64'd0, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0};
    vecs[7] = '{32'd10000, 32'd100000, 64'h0000_0000_3B9A_CA00, 1'b0};
    vecs[8] = '{32'h0001_0000, 32'h0000_8000, 64'h0000_0000_8000_0000, 1'b1};
    vecs[9] = '{32'hFFFF_0000, 32'h0000_8000, 64'hFFFF_FFFF_8000_0000, 1'b0};

    tick();
    tick();
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset p", p, 64'd0);
    check("reset ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, 1'b1, vecs[i].p, vecs[i].ovf_raw & OvfEn);
      finish_op($sformatf("vec%0d", i), 32, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      e  = model(ra, rb);
      launch(ra, rb, 1'b1, e.p, e.ovf);
      finish_op($sformatf("rnd%0d", i), 32, 1'b0);
    end

    // Start ignored while busy, then held through the DONE cycle and accepted there.
    d0 = done_cnt;
    launch(32'd2, 32'd3, 1'b1, 64'd6, 1'b0);
    repeat (10) tick();
    start = 1'b1;
    a     = 32'd100;
    b     = 32'd100;
    e.p   = 64'd10000;
    e.ovf = 1'b0;
    finish_op("ignored start", 22, 1'b1);
    sb.push_back(e);
    start = 1'b0;
    a     = 32'd7;
    b     = 32'd9;
    check("single done pulse", 64'(done_cnt - d0), 64'd1);
    finish_op("back to back", 32, 1'b0);

    // Reset in the middle of a run aborts it with no done.
    launch(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 64'd0, 1'b0);
    repeat (14) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid reset busy", {63'd0, busy}, 64'd0);
    check("mid reset p", p, 64'd0);
    check("mid reset ovf", {63'd0, ovf}, 64'd0);
    d0 = done_cnt;
    repeat (40) tick();
    check("no done after reset", 64'(done_cnt - d0), 64'd0);
    check("idle after reset", {63'd0, busy}, 64'd0);
    launch(32'd4, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    finish_op("after reset", 32, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
